fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage directly downstream of next-PC selection: owns the architectural PC register and the IF/ID pipeline register.
//  Each cycle, latches the selected next PC and presents the current PC to instruction memory.
//  Captures the returned instruction with PC, PC+8, delay-slot flag and fetch exception code, and hands the bundle to ID.
//  Honours hazard stalls and interrupt/eret flushes.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value after reset
//  IM_BASE   32'h0000_3000  lowest legal fetch address
//  IM_TOP    32'h0000_6FFC  highest legal fetch address (inclusive)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  npc           in   32  selected next PC (IRQ vector, EPC, branch/jump target or PC+4)
//  stall         in   1   hazard stall from ID: hold PC and IF/ID
//  flush         in   1   IRQ taken or eret issued: redirect and insert bubble
//  id_is_branch  in   1   instruction currently in ID is a branch/jump
//  im_rdata      in   32  instruction word at im_addr (combinational IM read)
//  pc            out  32  current fetch PC (to next-PC logic and IM)
//  im_addr       out  32  = pc
//  id_instr      out  32  IF/ID instruction
//  id_pc         out  32  IF/ID PC
//  id_pc8        out  32  IF/ID PC+8 (link value)
//  id_excode     out  5   IF/ID exception code: 0 = none, 4 = AdEL
//  id_bd         out  1   IF/ID instruction sits in a branch delay slot
//  id_valid      out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (reset_n low, async)
//   - pc = RESET_PC.
//   - id_instr = 0, id_pc = RESET_PC, id_pc8 = RESET_PC+8.
//   - id_excode = 0, id_bd = 0, id_valid = 0.
//   - Release takes effect on the next rising edge; the first fetch is RESET_PC.
//  Priority per edge: reset > flush > stall > advance.
//  Flush
//   - pc <= npc, even if stall=1.
//   - IF/ID <= bubble: instr 0, valid 0, bd 0, excode 0.
//   - id_pc <= pc, so CP0 still sees a sane PC.
//  Stall (flush=0)
//   - pc and every IF/ID field hold their values.
//   - npc is ignored.
//  Advance
//   - pc <= npc.
//   - IF/ID <= {instr, pc, pc+8, excode, id_is_branch, 1}.
//  Fetch check, combinational on pc
//   - AdEL when pc[1:0] != 0, pc < IM_BASE or pc > IM_TOP.
//   - On AdEL: excode = 4 and the latched instr is forced to 0 (nop); im_rdata is ignored.
//   - Otherwise excode = 0 and instr = im_rdata.
//  Delay slot
//   - bd is sampled from id_is_branch in the same cycle the slot instruction is latched.
//   - A stall holds both together.
//  Arithmetic: pc+8 is unsigned 32-bit and wraps modulo 2^32. No PC arithmetic other than +8.
//  Latency: fetch-to-ID is 1 cycle. A flush costs exactly 1 bubble.
//  Reset mid-stall or mid-flush: async reset wins immediately with no pending state kept.
//  No internal state other than pc and IF/ID.
// STRUCTURE
//  Shared header (head.v), used by the next-PC, CP0 and decode blocks:
//   - `PC_RESET, `IM_BASE, `IM_TOP
//   - `EXC_NONE = 5'd0, `EXC_ADEL = 5'd4
//   - `NOP = 32'h0
//  Sub-module if_id_reg:
//   - the IF/ID register with async reset, stall hold and flush-to-bubble.
//  fetch_stage itself holds:
//   - the PC register
//   - the fetch address check
//   - the if_id_reg instance
// TESTING
//  1. Reset: hold reset_n=0 3 cycles, release with npc=pc+4.
//     -> pc sequence 0x3000, 0x3004, 0x3008; id_valid rises 1 cycle after release.
//  2. Stall: assert stall for 2 cycles at pc=0x3010.
//     -> pc stays 0x3010 and id_pc stays 0x300C for both cycles, then resumes at 0x3014.
//  3. Flush during stall: stall=1, flush=1, npc=0x4180.
//     -> next cycle pc=0x4180, id_valid=0, id_instr=0.
//  4. Misaligned fetch: npc=0x3002.
//     -> next cycle id_excode=4 and id_instr=0; address 0x7000 also gives AdEL.
//  5. Delay slot: id_is_branch=1 while 0x3020 is fetched.
//     -> id_bd=1 with id_pc=0x3020; the following instruction has id_bd=0.
//  6. Async reset asserted mid-cycle during flush.
//     -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the IF stage.
//   PC_RESET / IM_BASE_ADDR / IM_TOP_ADDR : default reset PC and legal fetch window
//   EXC_NONE / EXC_ADEL                   : fetch exception codes
//   NOP                                   : instruction word used for bubbles and faulted fetches
//   if_id_t                               : IF/ID pipeline register bundle
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET     = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_ADDR  = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [4:0]  excode;
    logic        bd;
    logic        valid;
  } if_id_t;

  // Fetch address fault: misaligned or outside [base, top].
  function automatic logic fetch_adel(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > top);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset_n : clock, async active-low reset
//   stall        : hold every field
//   flush        : load a bubble (takes priority over stall)
//   bubble_pc    : PC recorded with a bubble so downstream still sees a sane PC
//   d            : bundle captured on advance
//   q            : registered bundle
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] bubble_pc,
  input  if_id_t      d,
  output if_id_t      q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.instr  <= NOP;
      q.pc     <= RESET_PC;
      q.pc8    <= RESET_PC + 32'd8;
      q.excode <= EXC_NONE;
      q.bd     <= 1'b0;
      q.valid  <= 1'b0;
    end else if (flush) begin
      q.instr  <= NOP;
      q.pc     <= bubble_pc;
      q.pc8    <= bubble_pc + 32'd8;
      q.excode <= EXC_NONE;
      q.bd     <= 1'b0;
      q.valid  <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch address check and IF/ID register.
//   clk, reset_n          : clock, async active-low reset
//   npc                   : selected next PC
//   stall, flush          : hazard hold / redirect-with-bubble (flush wins)
//   id_is_branch          : instruction in ID is a branch/jump, so this fetch is a delay slot
//   im_rdata              : combinational instruction memory data at im_addr
//   pc, im_addr           : current fetch PC
//   id_instr .. id_valid  : IF/ID outputs to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET,
  parameter logic [31:0] IM_BASE  = IM_BASE_ADDR,
  parameter logic [31:0] IM_TOP   = IM_TOP_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_is_branch,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] im_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic [4:0]  id_excode,
  output logic        id_bd,
  output logic        id_valid
);

  logic   adel;
  if_id_t fetch_d;
  if_id_t if_id_q;

  // Flush redirects even while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (flush || !stall) begin
      pc <= npc;
    end
  end

  assign im_addr = pc;
  assign adel    = fetch_adel(pc, IM_BASE, IM_TOP);

  // A faulted fetch never forwards memory data; decode sees a nop.
  always_comb begin
    fetch_d.instr  = adel ? NOP : im_rdata;
    fetch_d.pc     = pc;
    fetch_d.pc8    = pc + 32'd8;
    fetch_d.excode = adel ? EXC_ADEL : EXC_NONE;
    fetch_d.bd     = id_is_branch;
    fetch_d.valid  = 1'b1;
  end

  fetch_stage_if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .flush     (flush),
    .bubble_pc (pc),
    .d         (fetch_d),
    .q         (if_id_q)
  );

  assign id_instr  = if_id_q.instr;
  assign id_pc     = if_id_q.pc;
  assign id_pc8    = if_id_q.pc8;
  assign id_excode = if_id_q.excode;
  assign id_bd     = if_id_q.bd;
  assign id_valid  = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] npc;
  logic        stall;
  logic        flush;
  logic        id_is_branch;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] im_addr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic [4:0]  id_excode;
  logic        id_bd;
  logic        id_valid;

  logic        auto_inc;
  logic [31:0] npc_man;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Stimulus only: sequential next-PC and a recognisable memory pattern.
  assign npc      = auto_inc ? pc + 32'd4 : npc_man;
  assign im_rdata = {16'hA5A5, im_addr[15:0]};

  fetch_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .npc          (npc),
    .stall        (stall),
    .flush        (flush),
    .id_is_branch (id_is_branch),
    .im_rdata     (im_rdata),
    .pc           (pc),
    .im_addr      (im_addr),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc8       (id_pc8),
    .id_excode    (id_excode),
    .id_bd        (id_bd),
    .id_valid     (id_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; id_is_branch = 1'b0;
    auto_inc = 1'b1; npc_man = 32'h0;
    repeat (3) step();
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0000_3000); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr actual=%h required=0", id_instr); end
    checks++; if (id_pc !== 32'h0000_3000 || id_pc8 !== 32'h0000_3008) begin errors++; $display("FAIL reset_idpc actual=%h/%h required=3000/3008", id_pc, id_pc8); end
    checks++; if (id_excode !== 5'd0 || id_bd !== 1'b0) begin errors++; $display("FAIL reset_exc_bd actual=%0d/%b required=0/0", id_excode, id_bd); end
    checks++; if (im_addr !== 32'h0000_3000) begin errors++; $display("FAIL reset_imaddr actual=%h required=3000", im_addr); end
    reset_n = 1'b1;
    step();
    checks++; if (pc !== 32'h0000_3004) begin errors++; $display("FAIL rel1_pc actual=%h required=3004", pc); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_3000 || id_instr !== 32'hA5A5_3000) begin errors++; $display("FAIL rel1_id actual=%b/%h/%h required=1/3000/a5a53000", id_valid, id_pc, id_instr); end
    checks++; if (id_pc8 !== 32'h0000_3008) begin errors++; $display("FAIL rel1_pc8 actual=%h required=3008", id_pc8); end
    step();
    checks++; if (pc !== 32'h0000_3008 || id_pc !== 32'h0000_3004) begin errors++; $display("FAIL rel2 actual=%h/%h required=3008/3004", pc, id_pc); end
  endtask

  task automatic test_stall();
    step(); step();  // pc reaches 0x3010
    checks++; if (pc !== 32'h0000_3010 || id_pc !== 32'h0000_300C) begin errors++; $display("FAIL stall_pre actual=%h/%h required=3010/300c", pc, id_pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc !== 32'h0000_3010 || id_pc !== 32'h0000_300C || id_instr !== 32'hA5A5_300C) begin errors++; $display("FAIL stall_hold%0d actual=%h/%h/%h required=3010/300c/a5a5300c", i, pc, id_pc, id_instr); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h0000_3014 || id_pc !== 32'h0000_3010) begin errors++; $display("FAIL stall_resume actual=%h/%h required=3014/3010", pc, id_pc); end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1; auto_inc = 1'b0; npc_man = 32'h0000_4180;
    step();
    checks++; if (pc !== 32'h0000_4180) begin errors++; $display("FAIL flush_pc actual=%h required=4180", pc); end
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_bd !== 1'b0 || id_excode !== 5'd0) begin errors++; $display("FAIL flush_bubble actual=%b/%h/%b/%0d required=0/0/0/0", id_valid, id_instr, id_bd, id_excode); end
    checks++; if (id_pc !== 32'h0000_3014) begin errors++; $display("FAIL flush_idpc actual=%h required=3014", id_pc); end
    stall = 1'b0; flush = 1'b0; auto_inc = 1'b1;
    step();
    checks++; if (pc !== 32'h0000_4184 || id_valid !== 1'b1 || id_pc !== 32'h0000_4180 || id_instr !== 32'hA5A5_4180) begin errors++; $display("FAIL flush_after actual=%h/%b/%h/%h required=4184/1/4180/a5a54180", pc, id_valid, id_pc, id_instr); end
  endtask

  task automatic test_adel();
    auto_inc = 1'b0;
    npc_man = 32'h0000_3002; step();
    npc_man = 32'h0000_7000; step();
    checks++; if (id_excode !== 5'd4 || id_instr !== 32'h0 || id_pc !== 32'h0000_3002 || id_valid !== 1'b1) begin errors++; $display("FAIL adel_mis actual=%0d/%h/%h/%b required=4/0/3002/1", id_excode, id_instr, id_pc, id_valid); end
    npc_man = 32'h0000_6FFC; step();
    checks++; if (id_excode !== 5'd4 || id_instr !== 32'h0 || id_pc !== 32'h0000_7000) begin errors++; $display("FAIL adel_top actual=%0d/%h/%h required=4/0/7000", id_excode, id_instr, id_pc); end
    npc_man = 32'h0000_2FFC; step();
    checks++; if (id_excode !== 5'd0 || id_instr !== 32'hA5A5_6FFC) begin errors++; $display("FAIL adel_topok actual=%0d/%h required=0/a5a56ffc", id_excode, id_instr); end
    npc_man = 32'hFFFF_FFFC; step();
    checks++; if (id_excode !== 5'd4 || id_instr !== 32'h0 || id_pc !== 32'h0000_2FFC) begin errors++; $display("FAIL adel_base actual=%0d/%h/%h required=4/0/2ffc", id_excode, id_instr, id_pc); end
    npc_man = 32'h0000_3000; step();
    checks++; if (id_pc8 !== 32'h0000_0004 || id_excode !== 5'd4) begin errors++; $display("FAIL pc8_wrap actual=%h/%0d required=00000004/4", id_pc8, id_excode); end
    step();
    checks++; if (id_excode !== 5'd0 || id_instr !== 32'hA5A5_3000) begin errors++; $display("FAIL adel_baseok actual=%0d/%h required=0/a5a53000", id_excode, id_instr); end
  endtask

  task automatic test_delay_slot();
    auto_inc = 1'b0; npc_man = 32'h0000_3020; step();
    auto_inc = 1'b1; id_is_branch = 1'b1;
    step();
    checks++; if (id_bd !== 1'b1 || id_pc !== 32'h0000_3020) begin errors++; $display("FAIL bd_set actual=%b/%h required=1/3020", id_bd, id_pc); end
    id_is_branch = 1'b0; stall = 1'b1;
    step();
    checks++; if (id_bd !== 1'b1 || id_pc !== 32'h0000_3020) begin errors++; $display("FAIL bd_stall actual=%b/%h required=1/3020", id_bd, id_pc); end
    stall = 1'b0;
    step();
    checks++; if (id_bd !== 1'b0 || id_pc !== 32'h0000_3024) begin errors++; $display("FAIL bd_clear actual=%b/%h required=0/3024", id_bd, id_pc); end
  endtask

  task automatic test_async_reset();
    flush = 1'b1; auto_inc = 1'b0; npc_man = 32'h0000_4180;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0000_3000 || id_valid !== 1'b0 || id_pc !== 32'h0000_3000 || id_pc8 !== 32'h0000_3008 || id_instr !== 32'h0) begin errors++; $display("FAIL async_rst actual=%h/%b/%h/%h/%h required=3000/0/3000/3008/0", pc, id_valid, id_pc, id_pc8, id_instr); end
    flush = 1'b0; auto_inc = 1'b1;
    step();
    reset_n = 1'b1;
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL async_hold actual=%h required=3000", pc); end
    step();
    checks++; if (pc !== 32'h0000_3004 || id_pc !== 32'h0000_3000 || id_valid !== 1'b1) begin errors++; $display("FAIL async_restart actual=%h/%h/%b required=3004/3000/1", pc, id_pc, id_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_adel();
    test_delay_slot();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
